// File: rtl/sr_ff_bank.sv
// sr_ff_bank: a bank of WIDTH independent, edge-triggered SR flip-flops.
// Each channel resolves S=R=1 according to a shared MODE (hold, set-dominant,
// reset-dominant or toggle). A registered CONFLICT flag reports whether the
// previous enabled edge saw S&R on any channel, and CONF_CNT counts such
// edges, saturating at its maximum value.
module sr_ff_bank #(
  parameter int unsigned          WIDTH   = 8,
  parameter int unsigned          CNT_W   = 8,
  parameter logic [WIDTH-1:0]     RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic [1:0]       MODE,
  input  logic             CLR_CNT,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             CONFLICT,
  output logic [CNT_W-1:0] CONF_CNT
);

  // Conflict resolution encodings for MODE.
  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_SET    = 2'b01;
  localparam logic [1:0] MODE_RESET  = 2'b10;
  localparam logic [1:0] MODE_TOGGLE = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             conflict_q;
  logic             conflict_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [WIDTH-1:0] both_on;
  logic             any_conflict;

  assign both_on      = S & R;
  assign any_conflict = |both_on;

  // Per-channel next state; channels are resolved independently bit by bit.
  always_comb begin
    q_d = q_q;
    if (EN) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        unique case ({S[i], R[i]})
          2'b00: q_d[i] = q_q[i];
          2'b01: q_d[i] = 1'b0;
          2'b10: q_d[i] = 1'b1;
          default: begin
            unique case (MODE)
              MODE_HOLD:   q_d[i] = q_q[i];
              MODE_SET:    q_d[i] = 1'b1;
              MODE_RESET:  q_d[i] = 1'b0;
              MODE_TOGGLE: q_d[i] = ~q_q[i];
              default:     q_d[i] = q_q[i];
            endcase
          end
        endcase
      end
    end
  end

  // Conflict flag reflects only the most recent edge; a disabled edge clears it.
  always_comb begin
    conflict_d = EN & any_conflict;
  end

  // Saturating conflict counter; clear overrides any increment and ignores EN.
  always_comb begin
    cnt_d = cnt_q;
    if (CLR_CNT) begin
      cnt_d = '0;
    end else if (EN && any_conflict && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State registers with synchronous reset that overrides every other input.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q        <= RST_VAL;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      q_q        <= q_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
    end
  end

  // Qbar is derived from the same register so it can never equal Q.
  assign Q        = q_q;
  assign Qbar     = ~q_q;
  assign CONFLICT = conflict_q;
  assign CONF_CNT = cnt_q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed testbench for sr_ff_bank. Two instances share all inputs: the main
// one (8-bit counter, RST_VAL=8'hA5) and a second one with a 2-bit counter to
// exercise saturation. Expected values are hand-computed in the vectors below.
module tb_sr_ff_bank;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] s;
  logic [7:0] r;
  logic [1:0] mode;
  logic       clr_cnt;

  logic [7:0] q;
  logic [7:0] qbar;
  logic       conflict;
  logic [7:0] conf_cnt;

  logic [7:0] q2;
  logic [7:0] qbar2;
  logic       conflict2;
  logic [1:0] conf_cnt2;

  int total_cnt;
  int bad_cnt;

  sr_ff_bank #(
    .WIDTH  (8),
    .CNT_W  (8),
    .RST_VAL(8'hA5)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .EN      (en),
    .S       (s),
    .R       (r),
    .MODE    (mode),
    .CLR_CNT (clr_cnt),
    .Q       (q),
    .Qbar    (qbar),
    .CONFLICT(conflict),
    .CONF_CNT(conf_cnt)
  );

  sr_ff_bank #(
    .WIDTH  (8),
    .CNT_W  (2),
    .RST_VAL(8'hA5)
  ) dut_sat (
    .CLK     (clk),
    .RST     (rst),
    .EN      (en),
    .S       (s),
    .R       (r),
    .MODE    (mode),
    .CLR_CNT (clr_cnt),
    .Q       (q2),
    .Qbar    (qbar2),
    .CONFLICT(conflict2),
    .CONF_CNT(conf_cnt2)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Single checking task: counts every comparison and reports mismatches.
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one vector on the falling edge, then sample just after the rising edge.
  task automatic apply(input logic rst_i, input logic en_i, input logic [7:0] s_i,
                       input logic [7:0] r_i, input logic [1:0] mode_i, input logic clr_i);
    @(negedge clk);
    rst     = rst_i;
    en      = en_i;
    s       = s_i;
    r       = r_i;
    mode    = mode_i;
    clr_cnt = clr_i;
    @(posedge clk);
    #1;
  endtask

  // Check Q, Qbar, CONFLICT and both counters after a step.
  task automatic expect_all(input string tag, input logic [7:0] eq, input logic ec,
                            input logic [7:0] ecnt, input logic [1:0] ecnt2);
    check_val({tag, ".q"},        {24'd0, q},         {24'd0, eq});
    check_val({tag, ".qbar"},     {24'd0, qbar},      {24'd0, ~eq});
    check_val({tag, ".conflict"}, {31'd0, conflict},  {31'd0, ec});
    check_val({tag, ".cnt"},      {24'd0, conf_cnt},  {24'd0, ecnt});
    check_val({tag, ".cnt2"},     {30'd0, conf_cnt2}, {30'd0, ecnt2});
    check_val({tag, ".q2"},       {24'd0, q2},        {24'd0, eq});
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst = 1'b0; en = 1'b0; s = '0; r = '0; mode = 2'b00; clr_cnt = 1'b0;

    // Reset dominates every other input, including a conflict with CLR_CNT.
    apply(1'b1, 1'b1, 8'hFF, 8'hFF, 2'b11, 1'b1);
    expect_all("reset", 8'hA5, 1'b0, 8'd0, 2'd0);

    // Clear Q to 00, then basic set/reset and hold.
    apply(1'b0, 1'b1, 8'h00, 8'hFF, 2'b00, 1'b0);
    expect_all("clear_q", 8'h00, 1'b0, 8'd0, 2'd0);
    apply(1'b0, 1'b1, 8'h0F, 8'hF0, 2'b00, 1'b0);
    expect_all("basic_sr", 8'h0F, 1'b0, 8'd0, 2'd0);
    apply(1'b0, 1'b1, 8'h00, 8'h00, 2'b00, 1'b0);
    expect_all("basic_hold", 8'h0F, 1'b0, 8'd0, 2'd0);

    // All four conflict modes on successive edges, then a fifth conflict edge.
    apply(1'b0, 1'b1, 8'hFF, 8'hFF, 2'b00, 1'b0);
    expect_all("mode_hold", 8'h0F, 1'b1, 8'd1, 2'd1);
    apply(1'b0, 1'b1, 8'hFF, 8'hFF, 2'b01, 1'b0);
    expect_all("mode_set", 8'hFF, 1'b1, 8'd2, 2'd2);
    apply(1'b0, 1'b1, 8'hFF, 8'hFF, 2'b10, 1'b0);
    expect_all("mode_reset", 8'h00, 1'b1, 8'd3, 2'd3);
    apply(1'b0, 1'b1, 8'hFF, 8'hFF, 2'b11, 1'b0);
    expect_all("mode_toggle", 8'hFF, 1'b1, 8'd4, 2'd3);
    apply(1'b0, 1'b1, 8'hFF, 8'hFF, 2'b11, 1'b0);
    expect_all("sat_fifth", 8'h00, 1'b1, 8'd5, 2'd3);

    // Independent channels: Q=F0, S=CC, R=AA, toggle on the conflicting bits.
    apply(1'b0, 1'b1, 8'hF0, 8'h00, 2'b00, 1'b0);
    expect_all("set_f0", 8'hF0, 1'b0, 8'd5, 2'd3);
    apply(1'b0, 1'b1, 8'hCC, 8'hAA, 2'b11, 1'b0);
    expect_all("mixed_chan", 8'h5C, 1'b1, 8'd6, 2'd3);

    // Clear wins over a simultaneous increment; flag still reports the conflict.
    apply(1'b0, 1'b1, 8'hFF, 8'hFF, 2'b00, 1'b1);
    expect_all("clr_vs_inc", 8'h5C, 1'b1, 8'd0, 2'd0);

    // Single-channel conflict counts once; then disabled edges.
    apply(1'b0, 1'b1, 8'h01, 8'h01, 2'b00, 1'b0);
    expect_all("one_conf", 8'h5C, 1'b1, 8'd1, 2'd1);
    apply(1'b0, 1'b0, 8'hFF, 8'hFF, 2'b11, 1'b0);
    expect_all("en_off", 8'h5C, 1'b0, 8'd1, 2'd1);
    apply(1'b0, 1'b0, 8'h00, 8'hFF, 2'b00, 1'b1);
    expect_all("en_off_clr", 8'h5C, 1'b0, 8'd0, 2'd0);

    // Reset mid-operation, then the first normal edge after it.
    apply(1'b0, 1'b1, 8'hFF, 8'hFF, 2'b01, 1'b0);
    expect_all("pre_rst", 8'hFF, 1'b1, 8'd1, 2'd1);
    apply(1'b1, 1'b1, 8'hFF, 8'h00, 2'b00, 1'b0);
    expect_all("mid_rst", 8'hA5, 1'b0, 8'd0, 2'd0);

    // Pulsing RST between edges must not disturb state.
    #2;
    rst = 1'b1;
    #1;
    check_val("rst_between.q", {24'd0, q}, 32'h0000_00A5);
    rst = 1'b0;
    #1;

    apply(1'b0, 1'b1, 8'hFF, 8'h00, 2'b00, 1'b0);
    expect_all("post_rst", 8'hFF, 1'b0, 8'd0, 2'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
